bridge_rx: RTL
==============

# bridge_rx

Request decoder for the host-to-FPGA path of the UART bridge. Consumes received bytes from the UART receiver, parses ASCII read/write request frames, and emits one bus request per valid frame to the core bus. Downstream, the core bus returns read data to `bridge_tx`, which formats the response.

## Interface
Parameters:
- none; frame format fixed.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_i` in 8: received byte from UART receiver.
- `valid_i` in 1: `data_i` valid this cycle; one-cycle strobe per byte; no backpressure.
- `addr_o` out 16: request address.
- `data_o` out 16: write data; 0 for reads.
- `rw_o` out 1: 1 = write, 0 = read.
- `valid_o` out 1: one-cycle request strobe.
- `error_o` out 1: one-cycle strobe on a malformed frame.

## Operation
Frame formats:
- Read: `R` + 4 hex address digits + terminator.
- Write: `W` + 4 hex address digits + 4 hex data digits + terminator.
- Hex digits: `0-9`, `A-F`, `a-f`; most-significant digit first.
- Terminator: CR (0x0D) or LF (0x0A). CR LF gives one request; the trailing LF is ignored in IDLE.

States: IDLE, ADDR, DATA, TERM.
- IDLE: `R` or `W` latches `rw`, clears the shift registers and the digit counter, and goes to ADDR. CR or LF is ignored silently. Any other byte pulses `error_o`.
- ADDR: each hex digit shifts in as `addr = {addr[11:0], nibble}`. After the 4th digit, go to TERM for a read or DATA for a write.
- DATA: 4 hex digits shift into `data` the same way, then go to TERM.
- TERM: CR or LF commits the request and returns to IDLE.

Digit counter: 2 bits; wraps 3→0 on the state change.

Error handling, from any non-IDLE state:
- A non-hex byte in ADDR or DATA, or a non-terminator in TERM, pulses `error_o`, discards the frame and returns to IDLE.
- Exception: `R` or `W` never counts as an error. It restarts the frame (same as the IDLE handling), so the decoder resyncs after corrupted traffic.

Outputs:
- Registered, and held between strobes.
- `data_o` is forced to 0 on a read commit.

## Timing
- Reset values: `addr_o`=0, `data_o`=0, `rw_o`=0, `valid_o`=0, `error_o`=0, state=IDLE, counter=0.
- Reset mid-frame discards the partial frame immediately; no strobe is produced.
- Latency: `valid_o` rises on the clock edge after the cycle where `valid_i` presents the terminator. `addr_o`, `data_o` and `rw_o` are valid in the same cycle.
- `valid_o` and `error_o` are high for exactly one cycle and never high together.
- Back-to-back bytes (`valid_i` high on consecutive cycles) are fully supported: one byte per cycle with no stalls.
- A new frame may start on the cycle after a commit.
- The consumer must accept `valid_o` unconditionally; there is no ready signal.
- Cycles with `valid_i` low leave all state unchanged.

## Structure
- Package `bridge_pkg` holds:
  - ASCII constants: `ASCII_R`, `ASCII_W`, `ASCII_CR`, `ASCII_LF`.
  - The state enum `rx_state_t`.
  - Response constants shared with `bridge_tx`.
- Sub-module `hex_decode` (combinational):
  - input: byte;
  - outputs: 4-bit `nibble` and `is_hex`.
  - `bridge_tx` will later reuse it for encoding checks.

## Test plan
- `R1234\r\n` → one `valid_o` pulse with `addr_o`=0x1234, `rw_o`=0, `data_o`=0. No pulse for the LF.
- `WBEEFcafe\n`, bytes back-to-back on consecutive cycles → `addr_o`=0xBEEF, `data_o`=0xCAFE, `rw_o`=1; `valid_o` on the cycle after the LF.
- `R12G4\r` → `error_o` pulse on the `G` byte. No `valid_o`; the next `R0001\r` gives `addr_o`=0x0001.
- `W12R00FF\r` (restart mid-frame) → no error; a single read with `addr_o`=0x00FF.
- `R12345\r` (5th digit where a terminator is expected) → `error_o` on the `5`, no request. `rst_n` asserted after `W12` → outputs return to 0, and the following `RABCD\r` decodes to 0xABCD.
- Two frames `R0000\r` and `RFFFF\r` with an idle gap of 868 cycles per byte (UART pacing) → two pulses carrying 0x0000 and 0xFFFF.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the UART bridge: ASCII framing bytes, the
// receive-side decoder states and the response bytes emitted by bridge_tx.
package bridge_pkg;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Response bytes used by bridge_tx when acknowledging a request.
    localparam logic [7:0] RESP_ACK = 8'h4B;
    localparam logic [7:0] RESP_NAK = 8'h3F;
    localparam logic [7:0] RESP_EOL = ASCII_LF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_TERM = 2'd3
    } rx_state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/hex_decode.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module hex_decode (
    input  logic [7:0] data_i,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'd0;
        is_hex = 1'b0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            nibble = data_i[3:0];
            is_hex = 1'b1;
        end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                     (data_i >= 8'h61 && data_i <= 8'h66)) begin
            // Low nibble of 'A'/'a' is 1, so add 9 to land on 10.
            nibble = data_i[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/bridge_rx.sv
// Host-to-FPGA request decoder: parses ASCII R/W frames from the UART
// receiver and issues one registered bus request per well-formed frame.
module bridge_rx
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o,
    output logic        error_o
);

    rx_state_t   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        rw_q, rw_d;
    logic [15:0] addr_out_q, addr_out_d;
    logic [15:0] data_out_q, data_out_d;
    logic        rw_out_q, rw_out_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

    logic [3:0]  nibble;
    logic        is_hex;

    hex_decode u_hex_decode (
        .data_i (data_i),
        .nibble (nibble),
        .is_hex (is_hex)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rw_d       = rw_q;
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;
        rw_out_d   = rw_out_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        if (valid_i) begin
            // A command letter always (re)starts a frame, whatever state we are in.
            if (data_i == ASCII_R || data_i == ASCII_W) begin
                rw_d    = (data_i == ASCII_W);
                addr_d  = 16'd0;
                data_d  = 16'd0;
                cnt_d   = 2'd0;
                state_d = ST_ADDR;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!is_term(data_i)) error_d = 1'b1;
                    end
                    ST_ADDR: begin
                        if (is_hex) begin
                            addr_d = {addr_q[11:0], nibble};
                            cnt_d  = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) state_d = rw_q ? ST_DATA : ST_TERM;
                        end else begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (is_hex) begin
                            data_d = {data_q[11:0], nibble};
                            cnt_d  = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) state_d = ST_TERM;
                        end else begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_TERM: begin
                        if (is_term(data_i)) begin
                            valid_d    = 1'b1;
                            addr_out_d = addr_q;
                            data_out_d = rw_q ? data_q : 16'd0;
                            rw_out_d   = rw_q;
                        end else begin
                            error_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= 16'd0;
            data_q     <= 16'd0;
            rw_q       <= 1'b0;
            addr_out_q <= 16'd0;
            data_out_q <= 16'd0;
            rw_out_q   <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rw_q       <= rw_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
            rw_out_q   <= rw_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign addr_o  = addr_out_q;
    assign data_o  = data_out_q;
    assign rw_o    = rw_out_q;
    assign valid_o = valid_q;
    assign error_o = error_q;

endmodule
